// File: rtl/pdm_pkg.sv
// Shared PDM definitions: FSM states, sample width and the
// bit-clock half-period helper used by both PDM directions.
package pdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pdm_state_t;

    localparam int SAMPLE_W = 16;

    function automatic int half_count(input int clk_mhz, input int rate_hz);
        return (clk_mhz * 1000000) / (rate_hz * 2);
    endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock generator: 50% duty clock plus a one-cycle
// tick in the cycle the clock falls.
module pdm_clkgen
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ = 125,
    parameter int PDM_RATE = 2400000
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic run,
    output logic pdm_clk,
    output logic tick
);

    localparam int HALF = half_count(CLK_FREQ, PDM_RATE);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(HALF - 1));

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
            tick    <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick    <= wrap & pdm_clk;
            pdm_clk <= pdm_clk ^ wrap;
            cnt     <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pdm_output.sv
// PCM-to-PDM output path: two-deep sample buffer feeding a
// first-order error-feedback modulator with amplifier control.
module pdm_output
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ = 125,
    parameter int PDM_RATE = 2400000,
    parameter int OSR      = 64
) (
    input  logic                CLK_IN,
    input  logic                RST_N,
    input  logic                ENABLE,
    input  logic [SAMPLE_W-1:0] S_DATA,
    input  logic                S_VALID,
    output logic                S_READY,
    output logic                PDM_CLK,
    output logic                PDM_DATA,
    output logic                AUD_SD,
    output logic                UNDERRUN
);

    localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

    pdm_state_t          state;
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] nxt;
    logic                nv;
    logic [15:0]         acc;
    logic [OW-1:0]       osr_cnt;
    logic                tick;
    logic                hs;
    logic                last;
    logic [16:0]         sum;

    pdm_clkgen #(
        .CLK_FREQ (CLK_FREQ),
        .PDM_RATE (PDM_RATE)
    ) u_clkgen (
        .CLK_IN  (CLK_IN),
        .RST_N   (RST_N),
        .run     (ENABLE),
        .pdm_clk (PDM_CLK),
        .tick    (tick)
    );

    assign S_READY = (state == ST_PRIME) | ((state == ST_RUN) & ~nv);
    assign hs      = S_VALID & S_READY;
    assign last    = (osr_cnt == OW'(OSR - 1));
    // Offset-binary sample: flipping the MSB maps -32768..32767 onto 0..65535
    assign sum     = {1'b0, acc} + {1'b0, ~cur[15], cur[14:0]};

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cur      <= '0;
            nxt      <= '0;
            nv       <= 1'b0;
            acc      <= '0;
            osr_cnt  <= '0;
            PDM_DATA <= 1'b0;
            AUD_SD   <= 1'b0;
            UNDERRUN <= 1'b0;
        end else if (!ENABLE) begin
            state    <= ST_IDLE;
            cur      <= '0;
            nxt      <= '0;
            nv       <= 1'b0;
            acc      <= '0;
            osr_cnt  <= '0;
            PDM_DATA <= 1'b0;
            AUD_SD   <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            UNDERRUN <= 1'b0;
            unique case (state)
                ST_IDLE: state <= ST_PRIME;
                ST_PRIME: begin
                    if (hs) begin
                        cur     <= S_DATA;
                        osr_cnt <= '0;
                        state   <= ST_RUN;
                        AUD_SD  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        PDM_DATA <= sum[16];
                        acc      <= sum[15:0];
                        osr_cnt  <= last ? '0 : osr_cnt + 1'b1;
                    end
                    if (tick && last) begin
                        if (nv) begin
                            cur <= nxt;
                            nv  <= 1'b0;
                        end else if (hs) begin
                            cur <= S_DATA;
                        end else begin
                            cur      <= '0;
                            UNDERRUN <= 1'b1;
                        end
                    end else if (hs) begin
                        nxt <= S_DATA;
                        nv  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_output.sv
// Self-checking bench for pdm_output: cycle model built from
// tick timing, a sample queue and offset-binary accumulation.
module tb_pdm_output;

    localparam int H   = (125 * 1000000) / (2400000 * 2);
    localparam int P   = 2 * H;
    localparam int OSR = 64;

    logic        CLK_IN  = 1'b0;
    logic        RST_N   = 1'b0;
    logic        ENABLE  = 1'b0;
    logic [15:0] S_DATA  = 16'h0000;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic        PDM_CLK;
    logic        PDM_DATA;
    logic        AUD_SD;
    logic        UNDERRUN;

    always #5 CLK_IN = ~CLK_IN;

    pdm_output dut (
        .CLK_IN   (CLK_IN),
        .RST_N    (RST_N),
        .ENABLE   (ENABLE),
        .S_DATA   (S_DATA),
        .S_VALID  (S_VALID),
        .S_READY  (S_READY),
        .PDM_CLK  (PDM_CLK),
        .PDM_DATA (PDM_DATA),
        .AUD_SD   (AUD_SD),
        .UNDERRUN (UNDERRUN)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model
    int   n = 0, m_mode = 0, k = 0, cur = 0, acc = 0, s = 0;
    int   m_data = 0, m_und = 0, m_aud = 0;
    logic m_ready = 1'b0;
    bit   m_tick = 0, m_hs = 0, used = 0;
    int   q[$];
    int   ticks = 0, ones = 0, und_cnt = 0, accepts = 0, direct = 0;
    int   d_ones = 0, d_und = 0, d_acc = 0;

    always @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N || !ENABLE) begin
            n = 0; m_mode = 0; k = 0; cur = 0; acc = 0;
            m_data = 0; m_und = 0; m_aud = 0;
            m_ready = 1'b0; m_tick = 0; m_hs = 0;
            q.delete();
        end else begin
            m_hs   = S_VALID && m_ready;
            used   = 0;
            n++;
            m_tick = (n > 1) && ((n - 1) % P == 0);
            m_und  = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_hs) begin
                    cur = S_DATA; k = 0; m_mode = 2; m_aud = 1;
                    accepts++;
                end
            end else begin
                if (m_tick) begin
                    s      = acc + (cur ^ 'h8000);
                    m_data = (s >> 16) & 1;
                    acc    = s & 'hFFFF;
                    ticks++;
                    ones += m_data;
                    k++;
                    if (k == OSR) begin
                        k = 0;
                        if (q.size() > 0) cur = q.pop_front();
                        else if (m_hs) begin cur = S_DATA; used = 1; direct++; end
                        else begin cur = 0; m_und = 1; und_cnt++; end
                    end
                end
                if (m_hs && !used) q.push_back(S_DATA);
                if (m_hs) accepts++;
            end
            m_ready = (m_mode == 1) || (m_mode == 2 && q.size() == 0);
        end
    end

    always @(posedge CLK_IN)
        if (RST_N && ENABLE && S_VALID && S_READY) d_acc++;

    always @(negedge CLK_IN) begin
        chk("pdm_clk", PDM_CLK, (n / H) % 2);
        chk("pdm_data", PDM_DATA, m_data);
        chk("aud_sd", AUD_SD, m_aud);
        chk("s_ready", S_READY, m_ready);
        chk("underrun", UNDERRUN, m_und);
        if (m_tick && m_mode == 2) d_ones += PDM_DATA;
        if (UNDERRUN) d_und++;
    end

    task automatic start(input logic [15:0] d, input logic v);
        ENABLE = 1'b0;
        repeat (2) @(negedge CLK_IN);
        ticks = 0; ones = 0; d_ones = 0; d_und = 0;
        und_cnt = 0; accepts = 0; direct = 0; d_acc = 0;
        S_DATA = d; S_VALID = v; ENABLE = 1'b1;
    endtask

    task automatic wait_ticks(input int t);
        int g = 0;
        while (ticks < t && g < t * P + 4 * P) begin
            @(negedge CLK_IN);
            g++;
        end
        if (ticks < t) chk("tick_timeout", ticks, t);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_clk"}, PDM_CLK, 0);
        chk({tag, "_data"}, PDM_DATA, 0);
        chk({tag, "_aud"}, AUD_SD, 0);
        chk({tag, "_ready"}, S_READY, 0);
        chk({tag, "_und"}, UNDERRUN, 0);
    endtask

    initial begin
        int g;
        int o1;
        repeat (3) @(negedge CLK_IN);
        chk_zero("reset");
        RST_N = 1'b1;
        repeat (2) @(negedge CLK_IN);

        // midscale: alternating bits, exactly half ones
        start(16'h0000, 1'b1);
        wait_ticks(256);
        chk("mid_model_ones", ones, 128);
        chk("mid_dut_ones", d_ones, 128);

        // full negative: never a one
        start(16'h8000, 1'b1);
        wait_ticks(128);
        chk("neg_model_ones", ones, 0);
        chk("neg_dut_ones", d_ones, 0);

        // full positive from a cleared accumulator: only the first tick is 0
        start(16'h7FFF, 1'b1);
        wait_ticks(128);
        chk("pos_model_ones", ones, 127);
        chk("pos_dut_ones", d_ones, 127);

        // backpressure with a ramp
        start(16'h1000, 1'b1);
        g = 0;
        while (ticks < 256 && g < 256 * P + 4 * P) begin
            @(negedge CLK_IN);
            g++;
            if (m_hs) S_DATA = S_DATA + 16'h2345;
            if (g == 3) begin
                chk("bp_ready_drop", S_READY, 0);
                chk("bp_two_accepts", d_acc, 2);
            end
        end
        @(negedge CLK_IN);
        if (m_hs) S_DATA = S_DATA + 16'h2345;
        #1;
        chk("bp_model_accepts", accepts, 6);
        chk("bp_dut_accepts", d_acc, 6);
        chk("bp_no_underrun", d_und, 0);

        // underrun after three samples
        start(16'h4000, 1'b1);
        g = 0;
        while (accepts < 3 && g < 100 * P) begin
            @(negedge CLK_IN);
            g++;
        end
        S_VALID = 1'b0;
        chk("ur_three_accepts", accepts, 3);
        wait_ticks(192);
        o1 = d_ones;
        wait_ticks(320);
        chk("ur_density", d_ones - o1, 64);
        chk("ur_dut_count", d_und, 3);
        chk("ur_model_count", und_cnt, 3);
        chk("ur_aud_sd", AUD_SD, 1);

        // handshake exactly on the reload tick
        start(16'h8000, 1'b1);
        g = 0;
        while (accepts < 1 && g < 10 * P) begin
            @(negedge CLK_IN);
            g++;
        end
        S_VALID = 1'b0;
        wait_ticks(63);
        repeat (P - 1) @(negedge CLK_IN);
        S_DATA = 16'h7FFF; S_VALID = 1'b1;
        @(negedge CLK_IN);
        S_VALID = 1'b0;
        wait_ticks(70);
        chk("bd_direct", direct, 1);
        chk("bd_model_und", und_cnt, 0);
        chk("bd_dut_und", d_und, 0);
        chk("bd_model_ones", ones, 5);
        chk("bd_dut_ones", d_ones, 5);

        // enable drop, prime hold, async reset mid-stream
        start(16'h0000, 1'b1);
        wait_ticks(10);
        ENABLE = 1'b0;
        @(negedge CLK_IN);
        chk_zero("endrop");
        S_VALID = 1'b0; ENABLE = 1'b1;
        repeat (120) @(negedge CLK_IN);
        chk("prime_data", PDM_DATA, 0);
        chk("prime_ready", S_READY, 1);
        chk("prime_aud", AUD_SD, 0);
        S_VALID = 1'b1;
        repeat (P * 3) @(negedge CLK_IN);
        #2 RST_N = 1'b0;
        #1 chk_zero("arst");
        @(negedge CLK_IN);
        RST_N = 1'b1;
        @(negedge CLK_IN);
        chk("restart_ready", S_READY, 1);
        chk("restart_data", PDM_DATA, 0);

        ENABLE = 1'b0; S_VALID = 1'b0;
        repeat (3) @(negedge CLK_IN);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_output.md
PDM_OUTPUT -- requirements
Module: pdm_output

Interface
REQ-001 Parameter CLK_FREQ, default 125, system clock frequency in MHz.
REQ-002 Parameter PDM_RATE, default 2400000, PDM bit rate in Hz; half-period count HALF = (CLK_FREQ*1000000)/(PDM_RATE*2), equal to 26 at the defaults.
REQ-003 Parameter OSR, default 64, number of PDM bits per PCM sample.
REQ-004 CLK_IN  input  1  single system clock; all logic on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 ENABLE  input  1  level; 1 = modulator active, 0 = return to IDLE.
REQ-007 S_DATA  input  16  signed two's-complement PCM sample.
REQ-008 S_VALID  input  1  sample offered.
REQ-009 S_READY  output  1  sample accepted when S_VALID and S_READY are both 1 on a rising edge.
REQ-010 PDM_CLK  output  1  PDM bit clock, 50% duty, period 2*HALF cycles.
REQ-011 PDM_DATA  output  1  registered PDM bitstream.
REQ-012 AUD_SD  output  1  amplifier enable; 1 only in RUN.
REQ-013 UNDERRUN  output  1  one-cycle pulse when a sample boundary finds no sample.

Function
REQ-014 A half-period counter 0..HALF-1 runs while ENABLE=1; at HALF-1 it wraps to 0 and PDM_CLK toggles.
REQ-015 The modulator tick is the cycle in which PDM_CLK toggles 1->0; PDM_DATA changes only in the cycle after a tick, so data is stable across each PDM_CLK rising edge.
REQ-016 States: IDLE, PRIME, RUN; IDLE->PRIME when ENABLE=1; PRIME->RUN on the first accepted sample; any state->IDLE in the cycle after ENABLE=0.
REQ-017 In IDLE: counters, accumulator, buffers cleared; PDM_CLK=0, PDM_DATA=0, AUD_SD=0, S_READY=0.
REQ-018 In PRIME: PDM_CLK runs, PDM_DATA=0, S_READY=1; the first sample loads the current register and the OSR counter starts at 0.
REQ-019 Buffering: current register plus one next register with next_valid; in RUN, S_READY = ~next_valid.
REQ-020 The OSR counter advances on each tick; on the tick where it equals OSR-1 it wraps to 0 and the current register reloads.
REQ-021 Reload with next_valid=1: current <= next, next_valid <= 0.
REQ-022 Reload with next_valid=0 and a handshake in the same cycle: the incoming sample goes straight to current; no UNDERRUN.
REQ-023 Reload with next_valid=0 and no handshake: current <= 16'h0000 (midscale), UNDERRUN pulses for 1 cycle, and the state stays RUN.
REQ-024 Modulator: first-order error feedback.
  - u = S_DATA with MSB inverted (offset binary).
  - On each tick, sum[16:0] = acc[15:0] + u; PDM_DATA <= sum[16]; acc <= sum[15:0].
  - Ones density = u/65536 exactly over 65536 ticks.
REQ-025 The accumulator wraps modulo 2^16 with no saturation; the sample boundary does not reset acc.

Reset
REQ-026 RST_N=0 forces, asynchronously: state=IDLE, all counters=0, acc=0, current=0, next_valid=0, and outputs PDM_CLK=0, PDM_DATA=0, AUD_SD=0, S_READY=0, UNDERRUN=0.
REQ-027 Reset asserted mid-stream discards buffered samples; after release with ENABLE=1 the block enters PRIME on the next edge.

Structure
REQ-028 A shared package pdm_pkg holds the state enumeration, the sample width constant (16), and the half-period count function shared with the PDM input path.
REQ-029 One sub-module, pdm_clkgen, implements REQ-014/REQ-015 and outputs PDM_CLK and a tick pulse; the remaining logic stays in pdm_output.

Verification
REQ-030 Constant S_DATA=16'h0000 in RUN -> PDM_DATA alternates 1,0 on successive ticks, 50% ones over 1024 ticks.
REQ-031 S_DATA=16'h8000 -> PDM_DATA=0 on every tick; S_DATA=16'h7FFF -> exactly 1 zero in 65536 ticks.
REQ-032 Backpressure: S_VALID held 1 with an incrementing ramp -> S_READY drops after 2 accepts, and exactly one sample is accepted per 64 ticks (64*52 = 3328 cycles) with none lost or duplicated.
REQ-033 Underrun: stop S_VALID after 3 samples -> UNDERRUN pulses once per 64 ticks, the output density is 50%, and AUD_SD stays 1.
REQ-034 Boundary handshake: S_VALID rises in the exact reload cycle with next_valid=0 -> no UNDERRUN, and the new sample is used from the next tick.
REQ-035 RST_N pulsed or ENABLE dropped mid-sample -> all outputs 0 within 1 cycle; after restart, PRIME holds PDM_DATA=0 until the first accept.
